// File: rtl/mem_stage.sv
// Pipeline memory stage: checks alignment, runs one request/response handshake with
// the data bus per load/store, and registers the writeback result.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_pc,
    input  logic        mem_regfile_wren,
    input  logic [4:0]  mem_regfile_wt_addr,
    input  logic        mem_regfile_mem2reg,
    input  logic [31:0] mem_regfile_wt_val,
    input  logic [31:0] mem_regfile_rt_read_val,
    input  logic [2:0]  mem_lw_sw_type,
    input  logic [31:0] mem_dmm_addr,
    input  logic        mem_dmm_read,
    input  logic        mem_dmm_write,
    input  logic [3:0]  mem_dmm_byte_enable,
    input  logic        mem_exc_in,
    input  logic        exe_complete,
    input  logic        exception_flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        ready,
    output logic        mem_exception_mem_exchappen,
    output logic [4:0]  mem_exception_mem_exccode,
    output logic [31:0] mem_badvaddr,
    output logic [31:0] wb_pc,
    output logic        wb_regfile_wren,
    output logic [4:0]  wb_regfile_wt_addr,
    output logic [31:0] wb_regfile_wt_val
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] T_LB  = 3'd0;
    localparam logic [2:0] T_LBU = 3'd1;
    localparam logic [2:0] T_LH  = 3'd2;
    localparam logic [2:0] T_LHU = 3'd3;
    localparam logic [2:0] T_LW  = 3'd4;
    localparam logic [2:0] T_SB  = 3'd5;
    localparam logic [2:0] T_SH  = 3'd6;
    localparam logic [2:0] T_SW  = 3'd7;

    function automatic logic [31:0] extract_load(input logic [2:0] ty, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (ty)
            T_LB:    extract_load = {{24{b[7]}}, b};
            T_LBU:   extract_load = {24'd0, b};
            T_LH:    extract_load = {{16{h[15]}}, h};
            T_LHU:   extract_load = {16'd0, h};
            default: extract_load = word;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] ty, input logic [31:0] rt);
        case (ty)
            T_SB:    store_data = {4{rt[7:0]}};
            T_SH:    store_data = {2{rt[15:0]}};
            default: store_data = rt;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic        wb_wren_q, wb_wren_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_val_q, wb_val_d;

    logic is_half, is_word, misalign, issue, req_int, ready_int;

    always_comb begin
        is_half  = (mem_lw_sw_type == T_LH) || (mem_lw_sw_type == T_LHU) || (mem_lw_sw_type == T_SH);
        is_word  = (mem_lw_sw_type == T_LW) || (mem_lw_sw_type == T_SW);
        misalign = (mem_dmm_read || mem_dmm_write) &&
                   ((is_half && mem_dmm_addr[0]) || (is_word && (mem_dmm_addr[1:0] != 2'b00)));
        issue    = (mem_dmm_read || mem_dmm_write) && !misalign && !mem_exc_in && !exception_flush;
    end

    // Once in REQ the request is committed: flush cannot withdraw it.
    always_comb begin
        state_d   = state_q;
        rbuf_d    = rbuf_q;
        req_int   = 1'b0;
        ready_int = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_int = !issue;
                if (issue) state_d = S_REQ;
            end
            S_REQ: begin
                req_int = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        rbuf_d  = data_rdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_DONE;
                    rbuf_d  = data_rdata;
                end
            end
            default: begin
                ready_int = 1'b1;
                if (exe_complete) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wb_pc_d   = wb_pc_q;
        wb_addr_d = wb_addr_q;
        wb_val_d  = wb_val_q;
        wb_wren_d = 1'b0;
        if (ready_int && exe_complete) begin
            wb_pc_d   = mem_pc;
            wb_addr_d = mem_regfile_wt_addr;
            wb_val_d  = mem_regfile_mem2reg ?
                        extract_load(mem_lw_sw_type, mem_dmm_addr[1:0], rbuf_q) : mem_regfile_wt_val;
            wb_wren_d = mem_regfile_wren && !(mem_exc_in || misalign || exception_flush);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wb_pc_q   <= '0;
            wb_wren_q <= 1'b0;
            wb_addr_q <= '0;
            wb_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            wb_pc_q   <= wb_pc_d;
            wb_wren_q <= wb_wren_d;
            wb_addr_q <= wb_addr_d;
            wb_val_q  <= wb_val_d;
        end
    end

    always_ff @(posedge clk) begin
        rbuf_q <= rbuf_d;
    end

    // Bus and exception outputs follow the inputs, but read as zero while reset is held.
    assign data_req   = req_int;
    assign data_wr    = reset && mem_dmm_write;
    assign data_be    = (reset && mem_dmm_write) ? mem_dmm_byte_enable : 4'b0000;
    assign data_addr  = reset ? {mem_dmm_addr[31:2], 2'b00} : 32'd0;
    assign data_wdata = reset ? store_data(mem_lw_sw_type, mem_regfile_rt_read_val) : 32'd0;
    assign ready      = !reset || ready_int;

    assign mem_exception_mem_exchappen = reset && misalign;
    assign mem_exception_mem_exccode   = (reset && misalign) ? (mem_dmm_write ? 5'd5 : 5'd4) : 5'd0;
    assign mem_badvaddr                = (reset && misalign) ? mem_dmm_addr : 32'd0;

    assign wb_pc              = wb_pc_q;
    assign wb_regfile_wren    = wb_wren_q;
    assign wb_regfile_wt_addr = wb_addr_q;
    assign wb_regfile_wt_val  = wb_val_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues loads/stores and plays the memory bus,
// a monitor checks every writeback pulse against queued reference results.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_pc, mem_regfile_wt_val, mem_regfile_rt_read_val, mem_dmm_addr;
    logic        mem_regfile_wren, mem_regfile_mem2reg, mem_dmm_read, mem_dmm_write;
    logic [4:0]  mem_regfile_wt_addr;
    logic [2:0]  mem_lw_sw_type;
    logic [3:0]  mem_dmm_byte_enable;
    logic        mem_exc_in, exe_complete, exception_flush;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        ready, exchappen;
    logic [4:0]  exccode;
    logic [31:0] badvaddr, wb_pc, wb_regfile_wt_val;
    logic        wb_regfile_wren;
    logic [4:0]  wb_regfile_wt_addr;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .mem_pc(mem_pc), .mem_regfile_wren(mem_regfile_wren),
        .mem_regfile_wt_addr(mem_regfile_wt_addr), .mem_regfile_mem2reg(mem_regfile_mem2reg),
        .mem_regfile_wt_val(mem_regfile_wt_val), .mem_regfile_rt_read_val(mem_regfile_rt_read_val),
        .mem_lw_sw_type(mem_lw_sw_type), .mem_dmm_addr(mem_dmm_addr),
        .mem_dmm_read(mem_dmm_read), .mem_dmm_write(mem_dmm_write),
        .mem_dmm_byte_enable(mem_dmm_byte_enable), .mem_exc_in(mem_exc_in),
        .exe_complete(exe_complete), .exception_flush(exception_flush),
        .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .ready(ready), .mem_exception_mem_exchappen(exchappen),
        .mem_exception_mem_exccode(exccode), .mem_badvaddr(badvaddr),
        .wb_pc(wb_pc), .wb_regfile_wren(wb_regfile_wren),
        .wb_regfile_wt_addr(wb_regfile_wt_addr), .wb_regfile_wt_val(wb_regfile_wt_val)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [31:0] val;
    } wb_t;

    wb_t sb[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int access_size(input int ty);
        if (ty == 0 || ty == 1 || ty == 5) return 1;
        if (ty == 2 || ty == 3 || ty == 6) return 2;
        return 4;
    endfunction

    // Reference load result: shift the addressed lane down, mask, then sign-adjust.
    function automatic logic [31:0] ref_load(input int ty, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] w;
        int v;
        case (ty)
            0, 1: begin
                w = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00ff;
                v = int'(w);
                if (ty == 0 && v > 127) v = v - 256;
            end
            2, 3: begin
                w = (word >> (16 * int'(addr[1]))) & 32'h0000_ffff;
                v = int'(w);
                if (ty == 2 && v > 32767) v = v - 65536;
            end
            default: v = int'(word);
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input int ty, input logic [31:0] rt);
        if (ty == 5) return {24'd0, rt[7:0]} * 32'h0101_0101;
        if (ty == 6) return {16'd0, rt[15:0]} * 32'h0001_0001;
        return rt;
    endfunction

    task automatic txn(input int ty, input logic [31:0] addr, input logic [31:0] rt,
                       input logic exc, input logic flush, input logic wren,
                       input logic [31:0] rdata, input int aok, input int dok, input int hold);
        logic [31:0] pc, alu;
        logic [4:0]  wa;
        logic [3:0]  be;
        logic        st, mis, acc;
        int          rz;
        pc  = $urandom;
        alu = $urandom;
        wa  = 5'($urandom);
        st  = (ty >= 5);
        mis = (addr % 32'(access_size(ty))) != 0;
        acc = !mis && !exc && !flush;
        if (ty == 5)      be = 4'b0001 << addr[1:0];
        else if (ty == 6) be = addr[1] ? 4'b1100 : 4'b0011;
        else if (ty == 7) be = 4'b1111;
        else              be = 4'($urandom);

        mem_pc = pc; mem_regfile_wt_val = alu; mem_regfile_wt_addr = wa;
        mem_regfile_wren = wren; mem_regfile_mem2reg = !st; mem_regfile_rt_read_val = rt;
        mem_lw_sw_type = 3'(ty); mem_dmm_addr = addr; mem_dmm_read = !st; mem_dmm_write = st;
        mem_dmm_byte_enable = be; mem_exc_in = exc; exception_flush = flush;
        exe_complete = !acc;
        if (wren && !exc && !mis && !flush)
            sb.push_back('{pc: pc, wa: wa, val: (st ? alu : ref_load(ty, addr, rdata))});

        @(negedge clk);
        chk("exc_flag", 32'(exchappen), 32'(mis));
        chk("exc_code", 32'(exccode), mis ? (st ? 32'd5 : 32'd4) : 32'd0);
        chk("badvaddr", badvaddr, mis ? addr : 32'd0);
        chk("data_addr", data_addr, addr & 32'hffff_fffc);
        chk("req_idle", 32'(data_req), 32'd0);
        if (!acc) begin
            chk("ready_idle", 32'(ready), 32'd1);
            step();
            exe_complete = 1'b0;
            exception_flush = 1'b0;
        end else begin
            rz = ready ? 0 : 1;
            step();
            for (int i = 0; i < aok; i++) begin
                exception_flush = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (!ready) rz++;
                chk("req_hold", 32'(data_req), 32'd1);
                step();
            end
            exception_flush = 1'b0;
            data_addr_ok = 1'b1;
            data_data_ok = (dok == 0);
            data_rdata = (dok == 0) ? rdata : $urandom;
            @(negedge clk);
            if (!ready) rz++;
            chk("req_acc", 32'(data_req), 32'd1);
            chk("data_wr", 32'(data_wr), 32'(st));
            chk("data_be", 32'(data_be), st ? 32'(be) : 32'd0);
            if (st) chk("data_wdata", data_wdata, ref_wdata(ty, rt));
            step();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (dok > 0) begin
                for (int i = 0; i < dok - 1; i++) begin
                    data_rdata = $urandom;
                    @(negedge clk);
                    if (!ready) rz++;
                    chk("wait_noreq", 32'(data_req), 32'd0);
                    step();
                end
                data_data_ok = 1'b1;
                data_rdata = rdata;
                @(negedge clk);
                if (!ready) rz++;
                step();
                data_data_ok = 1'b0;
                data_rdata = $urandom;
            end
            chk("stall_len", 32'(rz), 32'(2 + aok + dok));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("done_ready", 32'(ready), 32'd1);
                chk("done_noreq", 32'(data_req), 32'd0);
                chk("done_nowb", 32'(wb_regfile_wren), 32'd0);
                step();
            end
            exe_complete = 1'b1;
            @(negedge clk);
            chk("done_ready", 32'(ready), 32'd1);
            step();
            exe_complete = 1'b0;
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expected result.
    wb_t e;
    always @(negedge clk) begin
        if (reset && wb_regfile_wren) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_spurious: got write pc=%h val=%h, expected no write", wb_pc, wb_regfile_wt_val);
            end else begin
                e = sb.pop_front();
                chk("wb_pc", wb_pc, e.pc);
                chk("wb_addr", 32'(wb_regfile_wt_addr), 32'(e.wa));
                chk("wb_val", wb_regfile_wt_val, e.val);
            end
        end
    end

    task automatic reset_in_wait();
        mem_lw_sw_type = 3'd4; mem_dmm_addr = 32'h0000_3000; mem_dmm_read = 1'b1;
        mem_dmm_write = 1'b0; mem_regfile_wren = 1'b1; mem_regfile_mem2reg = 1'b1;
        mem_exc_in = 1'b0; exception_flush = 1'b0; exe_complete = 1'b0;
        step();
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("rw_req", 32'(data_req), 32'd1);
        step();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rw_wait_ready", 32'(ready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rw_rst_ready", 32'(ready), 32'd1);
        chk("rw_rst_req", 32'(data_req), 32'd0);
        chk("rw_rst_wbpc", wb_pc, 32'd0);
        mem_dmm_read = 1'b0;
        mem_regfile_mem2reg = 1'b0;
        step();
        reset = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_post_ready", 32'(ready), 32'd1);
            chk("rw_post_req", 32'(data_req), 32'd0);
            step();
            data_data_ok = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        mem_pc = 32'h0000_0400; mem_regfile_wren = 1'b1; mem_regfile_wt_addr = 5'd3;
        mem_regfile_mem2reg = 1'b0; mem_regfile_wt_val = 32'h1111_2222;
        mem_regfile_rt_read_val = 32'hcafe_f00d; mem_lw_sw_type = 3'd7;
        mem_dmm_addr = 32'h0000_1001; mem_dmm_read = 1'b0; mem_dmm_write = 1'b1;
        mem_dmm_byte_enable = 4'b1111; mem_exc_in = 1'b0; exe_complete = 1'b1;
        exception_flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wr", 32'(data_wr), 32'd0);
        chk("rst_be", 32'(data_be), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_exc", 32'(exchappen), 32'd0);
        chk("rst_code", 32'(exccode), 32'd0);
        chk("rst_bad", badvaddr, 32'd0);
        chk("rst_wbpc", wb_pc, 32'd0);
        chk("rst_wbwren", 32'(wb_regfile_wren), 32'd0);
        chk("rst_wbval", wb_regfile_wt_val, 32'd0);
        step();
        mem_dmm_write = 1'b0;
        exe_complete = 1'b0;
        reset = 1'b1;
        step();

        txn(4, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_00f0, 1, 1, 0);
        txn(0, 32'h0000_1003, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 0, 0, 0);
        txn(1, 32'h0000_1003, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 0, 2, 1);
        txn(2, 32'h0000_1002, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8001_0000, 2, 0, 0);
        txn(6, 32'h0000_2002, 32'h1234_abcd, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1, 0);
        txn(4, 32'h0000_1001, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        txn(7, 32'h0000_2006, 32'h5555_aaaa, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        txn(4, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1357_9bdf, 0, 1, 3);
        txn(3, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0, 0);
        txn(5, 32'h0000_1001, 32'h0000_00a5, 1'b0, 1'b1, 1'b1, 32'h0, 0, 0, 0);
        reset_in_wait();
        txn(4, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0bad_f00d, 1, 2, 0);

        for (int n = 0; n < 60; n++) begin
            int          ty;
            logic [31:0] a;
            ty = int'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            txn(ty, a, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        repeat (2) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
